// File: rtl/xosera_pkg.sv
// Shared SPI command-byte field positions and sequencer state encoding.
// No logic of its own; the sequencer imports it.
package xosera_pkg;

  localparam int SPI_CMD_CS = 7;
  localparam int SPI_CMD_WR = 6;
  localparam int SPI_CMD_RS = 5;
  localparam int SPI_CMD_BS = 4;

  typedef enum logic [1:0] {
    SEQ_CMD_WAIT  = 2'd0,
    SEQ_DATA_WAIT = 2'd1,
    SEQ_BUS_CYCLE = 2'd2
  } spi_seq_state_t;

endpackage

// File: rtl/xosera_spi_bus_seq.sv
// SPI byte-packet to Xosera bus sequencer: CS low CS_HOLD_CYCLES cycles starting 1 cycle after a payload strobe.
// No backpressure: bytes arriving mid bus cycle are dropped and flagged in overrun_o.
module xosera_spi_bus_seq
  import xosera_pkg::*;
#(
  parameter int          CS_HOLD_CYCLES = 2,
  parameter logic [7:0]  IDLE_BYTE      = 8'hCB
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       spi_select_i,
  input  logic       rx_strobe_i,
  input  logic [7:0] rx_byte_i,
  input  logic       tx_strobe_i,
  output logic [7:0] tx_byte_o,
  output logic       bus_cs_n_o,
  output logic       bus_rd_nwr_o,
  output logic       bus_bytesel_o,
  output logic [3:0] bus_reg_num_o,
  output logic [7:0] bus_data_o,
  input  logic [7:0] bus_data_i,
  output logic       soft_reset_o,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam logic [3:0] HOLD_LOAD = 4'(CS_HOLD_CYCLES - 1);

  spi_seq_state_t state_q, state_d;
  logic       cs_q, cs_d;
  logic       wr_q, wr_d;
  logic [3:0] reg_q, reg_d;
  logic       bytesel_q, bytesel_d;
  logic [7:0] data_q, data_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] rd_latch_q, rd_latch_d;
  logic       rd_valid_q, rd_valid_d;
  logic       soft_reset_q, soft_reset_d;
  logic       overrun_q, overrun_d;
  logic       desel_q, desel_d;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q      <= SEQ_CMD_WAIT;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      reg_q        <= 4'h0;
      bytesel_q    <= 1'b0;
      data_q       <= 8'h00;
      hold_q       <= 4'h0;
      rd_latch_q   <= 8'h00;
      rd_valid_q   <= 1'b0;
      soft_reset_q <= 1'b0;
      overrun_q    <= 1'b0;
      desel_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      reg_q        <= reg_d;
      bytesel_q    <= bytesel_d;
      data_q       <= data_d;
      hold_q       <= hold_d;
      rd_latch_q   <= rd_latch_d;
      rd_valid_q   <= rd_valid_d;
      soft_reset_q <= soft_reset_d;
      overrun_q    <= overrun_d;
      desel_q      <= desel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    wr_d         = wr_q;
    reg_d        = reg_q;
    bytesel_d    = bytesel_q;
    data_d       = data_q;
    hold_d       = hold_q;
    rd_latch_d   = rd_latch_q;
    rd_valid_d   = rd_valid_q;
    soft_reset_d = 1'b0;
    overrun_d    = overrun_q;
    desel_d      = desel_q;

    // Placed first so a same-cycle read capture below overrides the clear.
    if (tx_strobe_i) rd_valid_d = 1'b0;

    unique case (state_q)
      SEQ_CMD_WAIT: begin
        if (!spi_select_i) begin
          rd_valid_d = 1'b0;
        end else if (rx_strobe_i) begin
          cs_d      = rx_byte_i[SPI_CMD_CS];
          wr_d      = rx_byte_i[SPI_CMD_WR];
          bytesel_d = rx_byte_i[SPI_CMD_BS];
          reg_d     = rx_byte_i[3:0];
          if (rx_byte_i[SPI_CMD_RS]) begin
            soft_reset_d = 1'b1;
            overrun_d    = 1'b0;
          end
          state_d = SEQ_DATA_WAIT;
        end
      end
      SEQ_DATA_WAIT: begin
        if (!spi_select_i) begin
          rd_valid_d = 1'b0;
          state_d    = SEQ_CMD_WAIT;
        end else if (rx_strobe_i) begin
          if (cs_q) begin
            data_d  = rx_byte_i;
            hold_d  = HOLD_LOAD;
            desel_d = 1'b0;
            state_d = SEQ_BUS_CYCLE;
          end else begin
            state_d = SEQ_CMD_WAIT;
          end
        end
      end
      SEQ_BUS_CYCLE: begin
        if (rx_strobe_i) overrun_d = 1'b1;
        // A deselect seen anywhere in the cycle is remembered until the cycle ends.
        if (!spi_select_i) desel_d = 1'b1;
        if (hold_q == 4'h0) begin
          bytesel_d = ~bytesel_q;
          if (!wr_q) begin
            rd_latch_d = bus_data_i;
            rd_valid_d = 1'b1;
          end
          desel_d = 1'b0;
          state_d = (desel_q || !spi_select_i) ? SEQ_CMD_WAIT : SEQ_DATA_WAIT;
        end else begin
          hold_d = hold_q - 4'h1;
        end
      end
      default: state_d = SEQ_CMD_WAIT;
    endcase
  end

  assign bus_cs_n_o    = (state_q != SEQ_BUS_CYCLE);
  assign busy_o        = (state_q == SEQ_BUS_CYCLE);
  assign bus_rd_nwr_o  = ~wr_q;
  assign bus_bytesel_o = bytesel_q;
  assign bus_reg_num_o = reg_q;
  assign bus_data_o    = data_q;
  assign soft_reset_o  = soft_reset_q;
  assign overrun_o     = overrun_q;
  assign tx_byte_o     = rd_valid_q ? rd_latch_q : IDLE_BYTE;

endmodule
